// File: rtl/score_render_pkg.sv
// Shared definitions for the score overlay: segment bit positions, the nibble-to-glyph
// table, the stage-1 pipeline record and cell geometry helpers.
package score_render_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Bit order {g,f,e,d,c,b,a}; codes above 9 draw a dash so corrupt BCD is visible.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

    typedef struct packed {
        logic        in_box;
        logic [2:0]  k;
        logic [11:0] lx;
        logic [11:0] ly;
    } stage1_t;

    function automatic logic [11:0] cell_left(int x0, int dw, int k);
        return 12'(x0 + k * dw);
    endfunction

endpackage

// File: rtl/score_render_if.sv
// Pixel-address stream, score load and frame strobe into the overlay, glyph pixel back out.
interface score_render_if #(
    parameter int NUM_DIGITS = 4
);
    logic [10:0]             col_addr;
    logic [10:0]             row_addr;
    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] score;
    logic                    score_valid;
    logic                    pixel_on_n;

    modport master (
        output col_addr, row_addr, frame_start, score, score_valid,
        input  pixel_on_n
    );

    modport slave (
        input  col_addr, row_addr, frame_start, score, score_valid,
        output pixel_on_n
    );
endinterface

// File: rtl/seven_seg_decode.sv
// Nibble to seven-segment mask; purely combinational table lookup.
module seven_seg_decode
    import score_render_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);
    assign segs = SEG_TABLE[nibble];
endmodule

// File: rtl/score_render.sv
// N-digit seven-segment score overlay: frame-latched digits, leading-zero blanking,
// post-change blink, two-stage pixel pipeline.
module score_render
    import score_render_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int X0           = 40,
    parameter int Y0           = 360,
    parameter int DIGIT_W      = 60,
    parameter int DIGIT_H      = 60,
    parameter int GAP          = 8,
    parameter int SEG_T        = 8,
    parameter int BLINK_FRAMES = 30,
    parameter int BLINK_HALF   = 4
) (
    input logic           clk,
    input logic           rst_n,
    score_render_if.slave bus
);

    localparam logic [11:0] X_LO   = 12'(X0);
    localparam logic [11:0] X_HI   = cell_left(X0, DIGIT_W, NUM_DIGITS);
    localparam logic [11:0] Y_LO   = 12'(Y0);
    localparam logic [11:0] Y_HI   = 12'(Y0 + DIGIT_H);
    localparam logic [11:0] GW     = 12'(DIGIT_W - GAP);
    localparam logic [11:0] GT     = 12'(SEG_T);
    localparam logic [11:0] D_TOP  = 12'(DIGIT_H - SEG_T);
    localparam logic [11:0] G_LO   = 12'((DIGIT_H - SEG_T) / 2);
    localparam logic [11:0] G_HI   = 12'((DIGIT_H + SEG_T) / 2);
    localparam logic [11:0] HALF_H = 12'(DIGIT_H / 2);
    localparam logic [11:0] R_COL  = 12'(DIGIT_W - GAP - SEG_T);
    localparam logic [15:0] BF     = 16'(BLINK_FRAMES);
    localparam logic [15:0] HL     = 16'(BLINK_HALF - 1);

    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] displayed;
    logic [15:0]             blink_cnt;
    logic [15:0]             half_cnt;
    logic                    hide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            displayed <= '0;
        end else begin
            if (bus.score_valid) pending <= bus.score;
            if (bus.frame_start) displayed <= pending;
        end
    end

    // Hide toggles on the first countdown frame and then every BLINK_HALF frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            half_cnt  <= '0;
            hide      <= 1'b0;
        end else if (bus.frame_start) begin
            if (pending != displayed && BLINK_FRAMES > 0) begin
                blink_cnt <= BF;
                half_cnt  <= '0;
                hide      <= 1'b0;
            end else if (blink_cnt != '0) begin
                blink_cnt <= blink_cnt - 16'd1;
                half_cnt  <= (half_cnt == HL) ? '0 : half_cnt + 16'd1;
                if (blink_cnt == 16'd1) hide <= 1'b0;
                else if (half_cnt == '0) hide <= ~hide;
            end
        end
    end

    // Stage 1: box test, digit index and cell-local coordinates
    logic [11:0] col12, row12, base;
    stage1_t     s1_d, s1_p1;

    always_comb begin
        col12 = {1'b0, bus.col_addr};
        row12 = {1'b0, bus.row_addr};
        base  = X_LO;
        s1_d  = '0;
        for (int j = 1; j < NUM_DIGITS; j++) begin
            if (col12 >= cell_left(X0, DIGIT_W, j)) begin
                s1_d.k = 3'(j);
                base   = cell_left(X0, DIGIT_W, j);
            end
        end
        s1_d.in_box = (col12 >= X_LO) && (col12 < X_HI) && (row12 >= Y_LO) && (row12 < Y_HI);
        s1_d.lx     = col12 - base;
        s1_d.ly     = row12 - Y_LO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_p1 <= '0;
        else        s1_p1 <= s1_d;
    end

    // Stage 2: glyph lookup, blanking and segment hit
    logic [3:0] digs [8];
    logic [7:0] blank_vec;
    logic       zero_run;
    logic [6:0] segs;
    logic       hit;
    logic       pix_p2;

    always_comb begin
        for (int i = 0; i < 8; i++) digs[i] = 4'd0;
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digs[i]      = displayed[4*(NUM_DIGITS-1-i) +: 4];
            zero_run     = zero_run && (digs[i] == 4'd0);
            blank_vec[i] = zero_run;
        end
        blank_vec[NUM_DIGITS-1] = 1'b0;
    end

    seven_seg_decode u_dec (
        .nibble (digs[s1_p1.k]),
        .segs   (segs)
    );

    always_comb begin
        hit = 1'b0;
        if (s1_p1.lx < GW) begin
            hit = (segs[SEG_A] && s1_p1.ly < GT)
               || (segs[SEG_D] && s1_p1.ly >= D_TOP)
               || (segs[SEG_G] && s1_p1.ly >= G_LO && s1_p1.ly < G_HI)
               || (segs[SEG_F] && s1_p1.lx < GT && s1_p1.ly < HALF_H)
               || (segs[SEG_E] && s1_p1.lx < GT && s1_p1.ly >= HALF_H)
               || (segs[SEG_B] && s1_p1.lx >= R_COL && s1_p1.ly < HALF_H)
               || (segs[SEG_C] && s1_p1.lx >= R_COL && s1_p1.ly >= HALF_H);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_p2 <= 1'b1;
        else        pix_p2 <= ~(s1_p1.in_box & hit & ~blank_vec[s1_p1.k] & ~hide);
    end

    assign bus.pixel_on_n = pix_p2;

endmodule
